// File: rtl/counter_ctrl.sv
// Start/stop sequencer for a WIDTH-bit up-counter with one-shot and auto-reload modes.
// Optional tick prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  reload,
  input  logic                  stop,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt, w_count_inc;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_reload_q;
  logic             r_done, w_done_nxt;
  logic             w_accept;
  logic             w_tick;

  assign w_accept    = start_valid && (r_state == S_IDLE);
  assign w_count_inc = r_count + WIDTH'(1);

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_prescale_q;
  logic [PRESCALE_W-1:0] r_div;

  // Divider restarts on every accepted command and on stop so each run is phase-aligned.
  assign w_tick = (r_div == r_prescale_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale_q <= '0;
      r_div        <= '0;
    end else if (w_accept) begin
      r_prescale_q <= prescale;
      r_div        <= '0;
    end else if (r_state == S_RUN) begin
      if (stop || w_tick) r_div <= '0;
      else                r_div <= r_div + PRESCALE_W'(1);
    end
  end
`else
  logic [PRESCALE_W-1:0] w_unused_ps;
  assign w_unused_ps = '0;
  assign w_tick      = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_count_nxt = '0;
          if (limit != '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
            if (reload) w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        // stop beats the terminal count, so a coincident stop never produces done
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (w_tick) begin
          if (r_limit_q == '0) begin
            w_done_nxt = 1'b1;
          end else if (r_count == r_limit_q) begin
            w_count_nxt = '0;
          end else if (w_count_inc == r_limit_q) begin
            w_count_nxt = r_limit_q;
            w_done_nxt  = 1'b1;
            if (!r_reload_q) w_state_nxt = S_IDLE;
          end else begin
            w_count_nxt = w_count_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_done     <= 1'b0;
      r_limit_q  <= '0;
      r_reload_q <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
      if (w_accept) begin
        r_limit_q  <= limit;
        r_reload_q <= reload;
      end
    end
  end

  assign count       = r_count;
  assign done        = r_done;
  assign busy        = (r_state == S_RUN);
  assign start_ready = (r_state == S_IDLE);

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random traffic
// compared against an arithmetic model (count = elapsed ticks, clamped or modulo).
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] limit;
  logic       reload;
  logic       stop;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // model state
  int m_cnt, m_L, m_k, m_c, m_P;
  bit m_busy, m_done, m_rl;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .limit       (limit),
    .reload      (reload),
    .stop        (stop),
`ifdef COUNTER_CTRL_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string where);
    cmp({where, ".count"}, 32'(count), 32'(m_cnt));
    cmp({where, ".busy"}, 32'(busy), 32'(m_busy));
    cmp({where, ".done"}, 32'(done), 32'(m_done));
    cmp({where, ".start_ready"}, 32'(start_ready), 32'(!m_busy));
  endtask

  task automatic model_reset();
    m_cnt = 0; m_L = 0; m_k = 0; m_c = 0; m_P = 0;
    m_busy = 0; m_done = 0; m_rl = 0;
  endtask

  // Output after k ticks of a run: one-shot clamps at L, reload wraps modulo L+1.
  task automatic model_eval();
    if (!m_rl) begin
      m_cnt  = m_k;
      m_done = (m_k == m_L);
      m_busy = (m_k < m_L);
    end else if (m_L == 0) begin
      m_cnt  = 0;
      m_done = 1;
    end else begin
      m_cnt  = m_k % (m_L + 1);
      m_done = (m_cnt == m_L);
    end
  endtask

  task automatic step(input string where);
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      if (stop) begin
        m_busy = 0;
        m_done = 0;
      end else begin
        m_c++;
        if (m_c % (m_P + 1) == 0) begin
          m_k++;
          model_eval();
        end else begin
          m_done = 0;
        end
      end
    end else begin
      m_done = 0;
      if (start_valid) begin
        m_L = int'(limit); m_rl = reload; m_k = 0; m_c = 0; m_cnt = 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        m_P = int'(prescale);
`else
        m_P = 0;
`endif
        if (m_L == 0) begin
          m_done = 1;
          m_busy = m_rl;
        end else begin
          m_busy = 1;
        end
      end
    end
    #1;
    check_all(where);
  endtask

  task automatic issue(input int lim, input bit rl);
    start_valid = 1'b1; limit = 4'(lim); reload = rl;
    step("accept");
    start_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; limit = '0; reload = 1'b0; stop = 1'b0; prescale = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // one-shot limit 12, then hold for 10 more cycles
    issue(12, 0);
    for (int i = 0; i < 22; i++) step("oneshot12");
    cmp("oneshot12.hold", 32'(count), 32'd12);

    // reload limit 3, two full periods, then stop freezes the count
    issue(3, 1);
    for (int i = 0; i < 9; i++) step("reload3");
    stop = 1'b1; step("reload3.stop");
    stop = 1'b0;
    for (int i = 0; i < 4; i++) step("reload3.after");

    // limit 0 one-shot: single done pulse, never busy
    issue(0, 0);
    for (int i = 0; i < 3; i++) step("limit0");

    // start while busy is dropped
    issue(5, 0);
    start_valid = 1'b1; limit = 4'd2; reload = 1'b1;
    for (int i = 0; i < 3; i++) step("busy_start");
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) step("busy_start.tail");

    // stop on the terminal edge suppresses done
    issue(3, 0);
    step("stopterm"); step("stopterm");
    stop = 1'b1; step("stopterm.edge");
    stop = 1'b0;
    cmp("stopterm.count", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) step("stopterm.after");

    // full range, no wrap
    issue(15, 0);
    for (int i = 0; i < 18; i++) step("limit15");
    cmp("limit15.final", 32'(count), 32'd15);

    // limit 0 with reload: done every tick until stop
    issue(0, 1);
    for (int i = 0; i < 3; i++) step("l0reload");
    stop = 1'b1; step("l0reload.stop");
    stop = 1'b0; step("l0reload.after");

    // async reset mid-run at count 5
    issue(9, 0);
    for (int i = 0; i < 5; i++) step("prereset");
    cmp("prereset.count", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("async_reset");
    step("reset_held");
    reset = 1'b0;
    step("post_reset");

`ifdef COUNTER_CTRL_PRESCALE_EN
    prescale = 4'd2;
    issue(4, 0);
    for (int i = 0; i < 14; i++) step("prescale2");
    prescale = 4'd0;
`endif

    // random traffic
    for (int i = 0; i < 400; i++) begin
      start_valid = ($urandom % 3) == 0;
      limit  = ($urandom % 2) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
      reload = ($urandom % 4) == 0;
      stop   = ($urandom % 8) == 0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      prescale = 4'($urandom_range(0, 2));
`endif
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
